id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode / operand-fetch pipeline stage for the simple 32-bit MIPS-style CPU. Sits between instruction fetch and execute. Drives the register file's combinational read ports with rs/rt, fixes up the returned operands (r0 forcing, write-back bypass) and decodes destination, immediate and write-enable. Result goes into a valid/ready output register. It also detects load-use hazards and honours a pipeline flush.

## Interface
- No parameters; datapath fixed at 32 bits, 32 registers.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts in_instr/in_pc this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  PC of instruction
- rf_rs  out  5  register-file read index 0 = in_instr[25:21] (combinational)
- rf_rt  out  5  register-file read index 1 = in_instr[20:16] (combinational)
- rf_rdata0  in  32  register-file read data for rf_rs
- rf_rdata1  in  32  register-file read data for rf_rt
- wb_en  in  1  write-back writes the register file at the next edge
- wb_rd  in  5  write-back destination
- wb_data  in  32  write-back value
- ex_load  in  1  instruction in EX is a valid LW
- ex_rd  in  5  destination of that LW
- flush  in  1  discard the stage contents (taken branch/jump)
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- out_pc  out  32  registered PC
- out_op  out  6  opcode [31:26]
- out_funct  out  6  funct [5:0]
- out_shamt  out  5  [10:6]
- out_a  out  32  operand A (rs value)
- out_b  out  32  operand B (rt value)
- out_imm  out  32  extended immediate
- out_dst  out  5  destination register, 0 when no write
- out_wen  out  1  instruction writes a register

## Operation
- Operand fixup, each port independently, in priority order:
  - index 0 -> 0. The register file never writes r0 and is not reset, so its value there must be ignored.
  - wb_en && wb_rd==index && index!=0 -> wb_data. This is the bypass: the register file only writes at the same edge.
  - otherwise -> rf_rdata.
- Destination and write enable:
  - op 0x00 (R-type): dst = [15:11], wen = 1.
  - op 0x08–0x0F and 0x23 (LW): dst = [20:16], wen = 1.
  - op 0x03 (JAL): dst = 31, wen = 1.
  - All others (SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, undefined): dst = 0, wen = 0.
  - dst == 0 forces wen = 0.
- Immediate:
  - op 0x0C/0x0D/0x0E: zero-extend [15:0].
  - op 0x0F (LUI): {[15:0],16'h0}.
  - op 0x02/0x03: {in_pc[31:28],[25:0],2'b00}.
  - Otherwise: sign-extend [15:0].
- Hazard: hz = in_valid && ex_load && ex_rd!=0 && (ex_rd==rs || (ex_rd==rt && op uses rt)). rt is used for R-type, SW, BEQ, BNE.
- Handshake:
  - adv = !out_valid || out_ready.
  - in_ready = flush || (adv && !hz).
  - At each edge, priority: flush -> out_valid<=0; else adv && hz -> out_valid<=0 (bubble); else adv -> out_valid<=in_valid and all out_* load; else hold.
- While out_valid && !out_ready, out_* are stable.

## Timing
- Latency 1 cycle: input accepted at edge N appears on out_* after edge N.
- Full throughput when out_ready stays high and there are no hazards.
- Load-use costs exactly one bubble. The LW leaves EX, so hz drops the next cycle.
- Reset: every out_* is 0, including out_valid=0. in_ready=1 in the first cycle after reset.
- flush together with in_valid: the instruction is consumed and dropped.
- flush together with out_ready=0: the output is still cleared.
- hz together with out_ready=0: hold takes effect (adv=0); the bubble is inserted later, once adv=1.
- Reset mid-operation clears out_valid immediately (asynchronous). No partial state survives.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI…OP_LUI, OP_LW, OP_SW);
  - field-slice widths;
  - a decoded-instruction struct type reused by execute.
- One natural sub-module, id_decode: purely combinational op -> dst/wen/imm/uses_rt. It is instantiated once.
- Bypass, hazard and the output register live in id_stage.

## Test plan
- ADDI r5,r0,-3 (0x2005FFFD), out_ready=1 -> next cycle out_imm=0xFFFFFFFD, out_dst=5, out_wen=1, out_a=0.
- ORI r2,r1,0x8000 with r1=0x10 -> out_imm=0x00008000, out_a=0x10.
- Bypass: ADD r3,r1,r2 while wb_en=1, wb_rd=2, wb_data=0xDEAD, rf_rdata1 stale=0x1 -> out_b=0xDEAD.
- Load-use: ex_load=1, ex_rd=4 with SUB r6,r4,r7 -> in_ready=0 and one cycle out_valid=0. The next cycle accepts; exactly one bubble.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0. Raising out_ready resumes with nothing lost and nothing duplicated.
- flush with out_valid=1 and out_ready=0 -> out_valid=0 next cycle. rst_n low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, field widths, the ID->EX record and operand fixup.
package cpu_pkg;
  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;
  localparam int IMM_W   = 16;
  localparam int TGT_W   = 26;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [XLEN-1:0]    imm;
    logic [REG_W-1:0]   dst;
    logic               wen;
  } id_ex_t;

  // r0 is never trusted from the RF; same-edge write-back is forwarded.
  function automatic logic [XLEN-1:0] fix_operand(
    input logic [REG_W-1:0] idx,
    input logic [XLEN-1:0]  rdata,
    input logic             wb_en,
    input logic [REG_W-1:0] wb_rd,
    input logic [XLEN-1:0]  wb_data
  );
    if (idx == '0) return '0;
    if (wb_en && (wb_rd == idx)) return wb_data;
    return rdata;
  endfunction
endpackage

// File: rtl/id_decode.sv
// Combinational opcode decode: destination, write enable, immediate, rt usage.
module id_decode
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]  instr,
  input  logic [3:0]       pc_hi,
  output logic [REG_W-1:0] dst,
  output logic             wen,
  output logic [XLEN-1:0]  imm,
  output logic             uses_rt
);
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] dst_raw;

  assign op = instr[31:26];

  always_comb begin
    dst_raw = '0;
    uses_rt = 1'b0;
    imm     = {{(XLEN-IMM_W){instr[15]}}, instr[15:0]};
    if (op == OP_RTYPE)                        dst_raw = instr[15:11];
    else if (op inside {[OP_ADDI:OP_LUI], OP_LW}) dst_raw = instr[20:16];
    else if (op == OP_JAL)                     dst_raw = 5'd31;
    if (op inside {OP_RTYPE, OP_SW, OP_BEQ, OP_BNE}) uses_rt = 1'b1;
    if (op inside {OP_ANDI, OP_ORI, OP_XORI}) imm = {{(XLEN-IMM_W){1'b0}}, instr[15:0]};
    else if (op == OP_LUI)                    imm = {instr[15:0], {(XLEN-IMM_W){1'b0}}};
    else if (op inside {OP_J, OP_JAL})        imm = {pc_hi, instr[TGT_W-1:0], 2'b00};
  end

  // A zero destination is never a write, so wen follows dst directly.
  assign dst = dst_raw;
  assign wen = (dst_raw != '0);
endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: RF read, bypass, load-use stall, valid/ready output register.
module id_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic [REG_W-1:0]   rf_rs,
  output logic [REG_W-1:0]   rf_rt,
  input  logic [XLEN-1:0]    rf_rdata0,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic               wb_en,
  input  logic [REG_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ex_load,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [OP_W-1:0]    out_op,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [XLEN-1:0]    out_a,
  output logic [XLEN-1:0]    out_b,
  output logic [XLEN-1:0]    out_imm,
  output logic [REG_W-1:0]   out_dst,
  output logic               out_wen
);
  logic [REG_W-1:0] dst;
  logic [XLEN-1:0]  imm;
  logic             wen, uses_rt, hz, adv;
  id_ex_t           nxt, q;

  assign rf_rs = in_instr[25:21];
  assign rf_rt = in_instr[20:16];

  id_decode u_dec (
    .instr   (in_instr),
    .pc_hi   (in_pc[31:28]),
    .dst     (dst),
    .wen     (wen),
    .imm     (imm),
    .uses_rt (uses_rt)
  );

  // The LW in EX leaves next cycle, so a single bubble always clears hz.
  assign hz = in_valid && ex_load && (ex_rd != '0) &&
              ((ex_rd == rf_rs) || ((ex_rd == rf_rt) && uses_rt));
  assign adv      = !out_valid || out_ready;
  assign in_ready = flush || (adv && !hz);

  always_comb begin
    nxt       = '0;
    nxt.pc    = in_pc;
    nxt.op    = in_instr[31:26];
    nxt.funct = in_instr[5:0];
    nxt.shamt = in_instr[10:6];
    nxt.a     = fix_operand(rf_rs, rf_rdata0, wb_en, wb_rd, wb_data);
    nxt.b     = fix_operand(rf_rt, rf_rdata1, wb_en, wb_rd, wb_data);
    nxt.imm   = imm;
    nxt.dst   = dst;
    nxt.wen   = wen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv && hz) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
      q         <= nxt;
    end
  end

  assign out_pc    = q.pc;
  assign out_op    = q.op;
  assign out_funct = q.funct;
  assign out_shamt = q.shamt;
  assign out_a     = q.a;
  assign out_b     = q.b;
  assign out_imm   = q.imm;
  assign out_dst   = q.dst;
  assign out_wen   = q.wen;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus a randomized scoreboard run.
module tb_id_stage;
  import cpu_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, in_ready, wb_en = 0, ex_load = 0, flush = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_pc = 0, rf_rdata0, rf_rdata1, wb_data = 0;
  logic [4:0]  rf_rs, rf_rt, wb_rd = 0, ex_rd = 0;
  logic        out_valid, out_wen;
  logic [31:0] out_pc, out_a, out_b, out_imm;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_shamt, out_dst;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] rf_mem [32];

  always #5 clk = ~clk;

  // Register file model: write at the edge, r0 returns garbage.
  always @(posedge clk) if (wb_en && wb_rd != 0) rf_mem[wb_rd] <= wb_data;
  assign rf_rdata0 = (rf_rs == 0) ? 32'hBAD0BAD0 : rf_mem[rf_rs];
  assign rf_rdata1 = (rf_rt == 0) ? 32'hBAD1BAD1 : rf_mem[rf_rt];

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_load(ex_load), .ex_rd(ex_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_funct(out_funct), .out_shamt(out_shamt), .out_a(out_a), .out_b(out_b),
    .out_imm(out_imm), .out_dst(out_dst), .out_wen(out_wen)
  );

  // Reference: build the expected decoded record straight from the ISA rules.
  function automatic id_ex_t model(input logic [31:0] i, input logic [31:0] pc,
                                   input logic we, input logic [4:0] wr, input logic [31:0] wd);
    id_ex_t e;
    int op;
    op      = int'(i[31:26]);
    e.pc    = pc;
    e.op    = i[31:26];
    e.funct = i[5:0];
    e.shamt = i[10:6];
    e.a     = (i[25:21] == 0) ? 32'h0 : (we && wr == i[25:21]) ? wd : rf_mem[i[25:21]];
    e.b     = (i[20:16] == 0) ? 32'h0 : (we && wr == i[20:16]) ? wd : rf_mem[i[20:16]];
    if (op == 12 || op == 13 || op == 14) e.imm = 32'(i[15:0]);
    else if (op == 15)                    e.imm = 32'(i[15:0]) * 65536;
    else if (op == 2 || op == 3)          e.imm = (pc & 32'hF000_0000) + 32'(i[25:0]) * 4;
    else                                  e.imm = 32'($signed(i[15:0]));
    if (op == 0)                                 e.dst = i[15:11];
    else if ((op >= 8 && op <= 15) || op == 35) e.dst = i[20:16];
    else if (op == 3)                            e.dst = 5'd31;
    else                                         e.dst = 5'd0;
    e.wen = (e.dst != 0);
    return e;
  endfunction

  function automatic id_ex_t observed();
    id_ex_t o;
    o = '{out_pc, out_op, out_funct, out_shamt, out_a, out_b, out_imm, out_dst, out_wen};
    return o;
  endfunction

  task automatic idle();
    in_valid = 0; flush = 0; wb_en = 0; ex_load = 0; out_ready = 1;
  endtask

  task automatic rf_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1; wb_rd = r; wb_data = d;
    @(negedge clk);
    wb_en = 0;
  endtask

  task automatic test_reset();
    idle();
    #12;
    n_cmp++;
    if ({out_valid, observed()} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", {out_valid, observed()});
    end
    @(negedge clk); rst_n = 1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_addi();
    id_ex_t o;
    in_valid = 1; in_instr = 32'h2005FFFD; in_pc = 32'h100;
    @(negedge clk); in_valid = 0;
    o = observed();
    n_cmp++;
    if (out_valid !== 1 || o.imm !== 32'hFFFFFFFD || o.dst !== 5 || o.wen !== 1 || o.a !== 0) begin
      n_bad++; $display("FAIL addi got vld=%b imm=%h dst=%0d wen=%b a=%h want 1 fffffffd 5 1 0",
                        out_valid, o.imm, o.dst, o.wen, o.a);
    end
    @(negedge clk);
  endtask

  task automatic test_ori();
    rf_write(1, 32'h10);
    in_valid = 1; in_instr = 32'h34228000; in_pc = 32'h104;
    @(negedge clk); in_valid = 0;
    n_cmp++;
    if (out_imm !== 32'h00008000 || out_a !== 32'h10 || out_dst !== 2) begin
      n_bad++; $display("FAIL ori got imm=%h a=%h dst=%0d want 00008000 10 2", out_imm, out_a, out_dst);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    rf_write(1, 32'h11);
    rf_write(2, 32'h1);
    in_valid = 1; in_instr = 32'h00221820; in_pc = 32'h108;
    wb_en = 1; wb_rd = 2; wb_data = 32'hDEAD;
    @(negedge clk); in_valid = 0; wb_en = 0;
    n_cmp++;
    if (out_b !== 32'hDEAD || out_a !== 32'h11 || out_dst !== 3 || out_wen !== 1) begin
      n_bad++; $display("FAIL bypass got b=%h a=%h dst=%0d wen=%b want dead 11 3 1", out_b, out_a, out_dst, out_wen);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    rf_write(4, 32'h44);
    rf_write(7, 32'h77);
    ex_load = 1; ex_rd = 4;
    in_valid = 1; in_instr = 32'h00873022; in_pc = 32'h200;
    #1; n_cmp++;
    if (in_ready !== 0) begin n_bad++; $display("FAIL loaduse_stall got rdy=%b want 0", in_ready); end
    @(negedge clk); ex_load = 0;
    n_cmp++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL loaduse_bubble got vld=%b want 0", out_valid); end
    #1; n_cmp++;
    if (in_ready !== 1) begin n_bad++; $display("FAIL loaduse_resume got rdy=%b want 1", in_ready); end
    @(negedge clk); in_valid = 0;
    n_cmp++;
    if (out_valid !== 1 || out_pc !== 32'h200 || out_a !== 32'h44 || out_b !== 32'h77 || out_dst !== 6) begin
      n_bad++; $display("FAIL loaduse_issue got vld=%b pc=%h a=%h b=%h dst=%0d want 1 200 44 77 6",
                        out_valid, out_pc, out_a, out_b, out_dst);
    end
    @(negedge clk); n_cmp++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL loaduse_dup got vld=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1; in_instr = 32'h20010005; in_pc = 32'h300;
    @(negedge clk);
    out_ready = 0; in_instr = 32'h34228000; in_pc = 32'h304;
    for (int k = 0; k < 3; k++) begin
      #1; n_cmp++;
      if (in_ready !== 0) begin n_bad++; $display("FAIL bp_ready cyc %0d got %b want 0", k, in_ready); end
      @(negedge clk); n_cmp++;
      if (out_valid !== 1 || out_pc !== 32'h300 || out_imm !== 32'h5) begin
        n_bad++; $display("FAIL bp_hold cyc %0d got vld=%b pc=%h imm=%h want 1 300 5", k, out_valid, out_pc, out_imm);
      end
    end
    out_ready = 1;
    @(negedge clk); in_valid = 0; n_cmp++;
    if (out_valid !== 1 || out_pc !== 32'h304 || out_imm !== 32'h8000) begin
      n_bad++; $display("FAIL bp_resume got vld=%b pc=%h imm=%h want 1 304 8000", out_valid, out_pc, out_imm);
    end
    @(negedge clk); n_cmp++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL bp_dup got vld=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1; in_instr = 32'h20010001; in_pc = 32'h400; out_ready = 0;
    @(negedge clk);
    flush = 1; in_pc = 32'h404;
    #1; n_cmp++;
    if (out_valid !== 1 || in_ready !== 1) begin
      n_bad++; $display("FAIL flush_pre got vld=%b rdy=%b want 1 1", out_valid, in_ready);
    end
    @(negedge clk); flush = 0; in_valid = 0; out_ready = 1; n_cmp++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL flush_clear got vld=%b want 0", out_valid); end
    @(negedge clk); n_cmp++;
    if (out_valid !== 0) begin n_bad++; $display("FAIL flush_drop got vld=%b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_instr = 32'h2005FFFD; in_pc = 32'h500;
    @(negedge clk);
    #2 rst_n = 0;
    #1 n_cmp++;
    if ({out_valid, observed()} !== '0) begin
      n_bad++; $display("FAIL async_reset got %h want 0", {out_valid, observed()});
    end
    @(negedge clk); idle(); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    id_ex_t q[$];
    id_ex_t e, o;
    logic [5:0] ops [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                             6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h10, 6'h01};
    logic hz_m, rdy_m, uses_rt;
    for (int r = 1; r < 8; r++) rf_write(5'(r), $urandom);
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = {ops[$urandom_range(0, 17)], 2'b0, 3'($urandom), 2'b0, 3'($urandom),
                   2'b0, 3'($urandom), 11'($urandom)};
      if ($urandom_range(0, 3) == 0) in_instr[25:0] = 26'($urandom);
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      ex_load   = ($urandom_range(0, 3) == 0);
      ex_rd     = 5'($urandom_range(0, 7));
      #1;
      uses_rt = in_instr[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05};
      hz_m  = in_valid && ex_load && ex_rd != 0 &&
              (ex_rd == in_instr[25:21] || (ex_rd == in_instr[20:16] && uses_rt));
      rdy_m = flush || (((q.size() == 0) || out_ready) && !hz_m);
      n_cmp++;
      if (out_valid !== (q.size() != 0) || in_ready !== rdy_m) begin
        n_bad++; $display("FAIL rnd_hs cyc %0d got vld=%b rdy=%b want vld=%b rdy=%b",
                          c, out_valid, in_ready, q.size() != 0, rdy_m);
      end
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front(); o = observed(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL rnd_data cyc %0d got %h want %h", c, o, e); end
      end
      if (flush) q.delete();
      else if (in_valid && rdy_m) q.push_back(model(in_instr, in_pc, wb_en, wb_rd, wb_data));
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ori();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
